// File: rtl/jtag_dtm_tap.sv
// JTAG TAP controller and RISC-V Debug Transport Module, fully in the clk domain.
// TCK/TMS/TDI are oversampled; DMI scans become a valid/ready request to the debug module.
`timescale 1ns/1ps
module jtag_dtm_tap #(
    parameter logic [31:0] IDCODE    = 32'h1e200a6d,
    parameter int          DMI_ABITS = 6,
    parameter logic [2:0]  DTM_IDLE  = 3'd5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jtag_TCK,
    input  logic                 jtag_TMS,
    input  logic                 jtag_TDI,
    output logic                 jtag_TDO,
    output logic                 dmi_req_valid,
    input  logic                 dmi_req_ready,
    output logic [DMI_ABITS-1:0] dmi_req_addr,
    output logic [31:0]          dmi_req_data,
    output logic [1:0]           dmi_req_op,
    input  logic                 dmi_resp_valid,
    input  logic [31:0]          dmi_resp_data,
    output logic                 dmi_hardreset
);
    localparam int         DR_W      = DMI_ABITS + 34;
    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_e;

    tap_state_e state, state_next;
    logic tck_s1, tck_s2, tck_s3, tms_s1, tms_s2, tdi_s1, tdi_s2;
    logic tck_rise, tck_fall;
    logic capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, enter_tlr;

    logic [4:0]           ir, ir_sr;
    logic [DR_W-1:0]      dr_sr, dr_capture, dr_shifted;
    logic [31:0]          dtmcs_value;
    logic                 busy, outstanding;
    logic [31:0]          resp_reg;
    logic [DMI_ABITS-1:0] last_addr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            {tck_s1, tck_s2, tck_s3} <= 3'b000;
            {tms_s1, tms_s2}         <= 2'b00;
            {tdi_s1, tdi_s2}         <= 2'b00;
        end else begin
            tck_s1 <= jtag_TCK;
            tck_s2 <= tck_s1;
            tck_s3 <= tck_s2;
            tms_s1 <= jtag_TMS;
            tms_s2 <= tms_s1;
            tdi_s1 <= jtag_TDI;
            tdi_s2 <= tdi_s1;
        end
    end

    assign tck_rise = tck_s2 & ~tck_s3;
    assign tck_fall = ~tck_s2 & tck_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          state <= TLR;
        else if (tck_rise) state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            TLR:      state_next = tms_s2 ? TLR      : RTI;
            RTI:      state_next = tms_s2 ? SEL_DR   : RTI;
            SEL_DR:   state_next = tms_s2 ? SEL_IR   : CAP_DR;
            CAP_DR:   state_next = tms_s2 ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_next = tms_s2 ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_next = tms_s2 ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_next = tms_s2 ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_next = tms_s2 ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_next = tms_s2 ? SEL_DR   : RTI;
            SEL_IR:   state_next = tms_s2 ? TLR      : CAP_IR;
            CAP_IR:   state_next = tms_s2 ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_next = tms_s2 ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_next = tms_s2 ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_next = tms_s2 ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_next = tms_s2 ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_next = tms_s2 ? SEL_DR   : RTI;
            default:  state_next = TLR;
        endcase
    end

    // Capture, shift and update all act on the TCK rise that leaves the named state.
    always_comb begin
        capture_dr = tck_rise && (state == CAP_DR);
        shift_dr   = tck_rise && (state == SHIFT_DR);
        update_dr  = tck_rise && (state == UPD_DR);
        capture_ir = tck_rise && (state == CAP_IR);
        shift_ir   = tck_rise && (state == SHIFT_IR);
        update_ir  = tck_rise && (state == UPD_IR);
        enter_tlr  = tck_rise && (state_next == TLR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir    <= IR_IDCODE;
            ir_sr <= 5'b00000;
        end else begin
            if (capture_ir)    ir_sr <= 5'b00001;
            else if (shift_ir) ir_sr <= {tdi_s2, ir_sr[4:1]};
            if (enter_tlr)      ir <= IR_IDCODE;
            else if (update_ir) ir <= ir_sr;
        end
    end

    always_comb begin
        dtmcs_value = {14'b0, 1'b0, 1'b0, 1'b0, DTM_IDLE, (busy ? 2'b11 : 2'b00),
                       6'(DMI_ABITS), 4'd1};
        dr_capture  = '0;
        case (ir)
            IR_IDCODE: dr_capture = {{(DR_W-32){1'b0}}, IDCODE};
            IR_DTMCS:  dr_capture = {{(DR_W-32){1'b0}}, dtmcs_value};
            IR_DMI:    dr_capture = {last_addr, resp_reg,
                                     ((busy || outstanding) ? 2'b11 : 2'b00)};
            default:   dr_capture = '0;
        endcase
        // TDI enters at the top of the selected length so the upper bits stay zero.
        dr_shifted = dr_sr >> 1;
        case (ir)
            IR_IDCODE, IR_DTMCS: dr_shifted[31]     = tdi_s2;
            IR_DMI:              dr_shifted[DR_W-1] = tdi_s2;
            default: begin
                dr_shifted    = '0;
                dr_shifted[0] = tdi_s2;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            dr_sr <= '0;
        else if (capture_dr) dr_sr <= dr_capture;
        else if (shift_dr)   dr_sr <= dr_shifted;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          jtag_TDO <= 1'b0;
        else if (tck_fall) jtag_TDO <= (state == SHIFT_IR) ? ir_sr[0] :
                                       (state == SHIFT_DR) ? dr_sr[0] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy          <= 1'b0;
            outstanding   <= 1'b0;
            resp_reg      <= '0;
            last_addr     <= '0;
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= 2'b00;
            dmi_hardreset <= 1'b0;
        end else begin
            dmi_hardreset <= 1'b0;
            if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
            if (dmi_resp_valid && outstanding) begin
                resp_reg    <= dmi_resp_data;
                outstanding <= 1'b0;
            end
            if (enter_tlr) busy <= 1'b0;
            if (update_dr && ir == IR_DTMCS) begin
                if (dr_sr[16]) busy <= 1'b0;
                if (dr_sr[17]) begin
                    dmi_hardreset <= 1'b1;
                    dmi_req_valid <= 1'b0;
                    outstanding   <= 1'b0;
                end
            end
            // A response landing on the same clk still sees outstanding set, so the scan is busy.
            if (update_dr && ir == IR_DMI) begin
                if (outstanding) begin
                    busy <= 1'b1;
                end else begin
                    last_addr <= dr_sr[DR_W-1:34];
                    if (dr_sr[1:0] == 2'd1 || dr_sr[1:0] == 2'd2) begin
                        dmi_req_addr  <= dr_sr[DR_W-1:34];
                        dmi_req_data  <= dr_sr[33:2];
                        dmi_req_op    <= dr_sr[1:0];
                        dmi_req_valid <= 1'b1;
                        outstanding   <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
